// File: rtl/csa_tree_add_pkg.sv
// csa_pkg: shared sizing helpers and types for the carry-save adder tree.
//   csa_rows(n, lvl) : number of rows left after lvl 3:2 levels from n rows
//   csa_levels(n)    : number of 3:2 levels needed to reduce n rows to two
//   csa_ow(w, n)     : exact result width for n operands of w bits
//   csa_mode_e       : operand interpretation (unsigned / two's complement)
package csa_pkg;

    typedef enum logic {
        CSA_UNSIGNED = 1'b0,
        CSA_SIGNED   = 1'b1
    } csa_mode_e;

    // Each level turns every full triple into two rows; leftovers pass through.
    function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
        int unsigned r;
        r = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n);
        int unsigned r;
        int unsigned cnt;
        r   = n;
        cnt = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (r > 2) begin
                r   = 2 * (r / 3) + (r % 3);
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    function automatic int unsigned csa_ow(input int unsigned w, input int unsigned n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: one row of full adders (3:2 compressor), purely combinational.
//   a, b, c : three W-bit input rows
//   sum     : bitwise sum row
//   carry   : bitwise carry row, NOT shifted (the parent applies the << 1)
module csa_3to2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/csa_tree_add.sv
// csa_tree_add: pipelined NUM_OPS-operand adder built from registered 3:2
// carry-save levels followed by a registered carry-propagate add.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready = global advance enable)
//   in_ops                : packed operands, op k at [k*WIDTH +: WIDTH]
//   in_signed             : 1 = two's-complement operands, 0 = unsigned
//   in_tag                : sideband tag carried with the transaction
//   out_valid / out_ready : output handshake
//   out_sum               : exact OW-bit sum
//   out_tag               : tag belonging to out_sum
// Latency is LEVELS+1 register stages; the whole pipe stalls together.
module csa_tree_add
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned TAG_W   = 4,
    localparam int unsigned OW     = csa_ow(WIDTH, NUM_OPS),
    localparam int unsigned LEVELS = csa_levels(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic                     in_signed,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OW-1:0]            out_sum,
    output logic [TAG_W-1:0]         out_tag
);

    logic      en;
    csa_mode_e mode;

    // Stage 0..LEVELS-1 are tree levels, stage LEVELS is the CPA register.
    logic [LEVELS:0] vld_q;
    logic [TAG_W-1:0] tag_q [LEVELS+1];
    logic [OW-1:0]    sum_q;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign mode     = in_signed ? CSA_SIGNED : CSA_UNSIGNED;

    // g_lvl[0].row holds the extended operands (combinational);
    // g_lvl[l].row for l >= 1 is the registered output of tree level l.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned NR = csa_rows(NUM_OPS, l);
        logic [OW-1:0] row [NR];

        if (l == 0) begin : g_ext
            for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
                logic [WIDTH-1:0] op;
                assign op     = in_ops[k*WIDTH +: WIDTH];
                assign row[k] = (mode == CSA_SIGNED) ? {{(OW-WIDTH){op[WIDTH-1]}}, op}
                                                     : {{(OW-WIDTH){1'b0}}, op};
            end
        end else begin : g_red
            localparam int unsigned NP = csa_rows(NUM_OPS, l - 1);
            localparam int unsigned NT = NP / 3;
            logic [OW-1:0] nxt [NR];

            for (genvar t = 0; t < NT; t++) begin : g_tri
                logic [OW-1:0] s;
                logic [OW-1:0] c;
                csa_3to2 #(.W(OW)) u_csa (
                    .a     (g_lvl[l-1].row[3*t]),
                    .b     (g_lvl[l-1].row[3*t+1]),
                    .c     (g_lvl[l-1].row[3*t+2]),
                    .sum   (s),
                    .carry (c)
                );
                // Carry weight is one bit higher; the bit shifted out is
                // dropped because all tree arithmetic is modulo 2^OW.
                assign nxt[2*t]   = s;
                assign nxt[2*t+1] = c << 1;
            end

            for (genvar j = 0; j < NP % 3; j++) begin : g_pass
                assign nxt[2*NT+j] = g_lvl[l-1].row[3*NT+j];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < NR; i++) begin
                        row[i] <= '0;
                    end
                end else if (en) begin
                    for (int unsigned i = 0; i < NR; i++) begin
                        row[i] <= nxt[i];
                    end
                end
            end
        end
    end

    // Final carry-propagate stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= g_lvl[LEVELS].row[0] + g_lvl[LEVELS].row[1];
        end
    end

    // Valid and tag shift chain, moving in lockstep with the data stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i <= LEVELS; i++) begin
                tag_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int unsigned i = 1; i <= LEVELS; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LEVELS];
    assign out_sum   = sum_q;
    assign out_tag   = tag_q[LEVELS];

endmodule

// File: tb/tb_csa_tree_add.sv
// Self-checking bench for csa_tree_add: a default instance (32b x 4 ops) and
// an odd instance (8b x 3 ops), with directed cases, a randomized
// backpressured stream checked against an arithmetic reference model, and
// mid-stream reset.
module tb_csa_tree_add;

    localparam int unsigned LAT_A = 3;
    localparam int unsigned LAT_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default instance
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_ops = '0;
    logic          in_signed = 1'b0;
    logic [3:0]    in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [33:0]   out_sum;
    logic [3:0]    out_tag;

    // Odd instance
    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [23:0]   b_in_ops = '0;
    logic          b_in_signed = 1'b0;
    logic [3:0]    b_in_tag = '0;
    logic          b_out_valid;
    logic          b_out_ready = 1'b1;
    logic [9:0]    b_out_sum;
    logic [3:0]    b_out_tag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        logic [33:0] s;
        logic [3:0]  t;
    } exp_t;

    exp_t        exp_q[$];
    bit          stream_on = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_sum;
    logic [3:0]  prev_tag;
    int unsigned n_rx = 0;

    always #5 clk = ~clk;

    csa_tree_add #(.WIDTH(32), .NUM_OPS(4), .TAG_W(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag)
    );

    csa_tree_add #(.WIDTH(8), .NUM_OPS(3), .TAG_W(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_ops    (b_in_ops),
        .in_signed (b_in_signed),
        .in_tag    (b_in_tag),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_tag   (b_out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: interpret each operand as an integer, add, reduce mod 2^34.
    function automatic logic [33:0] ref_sum(input logic [127:0] ops, input bit sgn);
        longint      acc;
        logic [31:0] op;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            op = ops[k*32 +: 32];
            if (sgn) acc += longint'($signed(op));
            else     acc += longint'({32'b0, op});
        end
        return acc[33:0];
    endfunction

    task automatic run_a(input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                         input logic [31:0] o3, input bit sgn, input logic [3:0] tag,
                         input logic [33:0] exp, input string nm);
        @(posedge clk); #1;
        in_ops    = {o3, o2, o1, o0};
        in_signed = sgn;
        in_tag    = tag;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        for (int i = 1; i < LAT_A; i++) begin
            @(negedge clk);
            check({nm, "_early_vld"}, 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check({nm, "_vld"}, 64'(out_valid), 64'd1);
        check({nm, "_sum"}, 64'(out_sum), 64'(exp));
        check({nm, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    task automatic run_b(input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2,
                         input bit sgn, input logic [3:0] tag, input logic [9:0] exp,
                         input string nm);
        @(posedge clk); #1;
        b_in_ops    = {o2, o1, o0};
        b_in_signed = sgn;
        b_in_tag    = tag;
        b_in_valid  = 1'b1;
        @(posedge clk); #1;
        b_in_valid  = 1'b0;
        for (int i = 1; i < LAT_B; i++) begin
            @(negedge clk);
            check({nm, "_early_vld"}, 64'(b_out_valid), 64'd0);
        end
        @(negedge clk);
        check({nm, "_vld"}, 64'(b_out_valid), 64'd1);
        check({nm, "_sum"}, 64'(b_out_sum), 64'(exp));
        check({nm, "_tag"}, 64'(b_out_tag), 64'(tag));
    endtask

    // Stream monitor: handshake relation, in-order results, stall stability.
    always @(negedge clk) begin
        if (stream_on) begin
            exp_t e;
            check("in_ready_rel", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("stall_vld", 64'(out_valid), 64'd1);
                check("stall_sum", 64'(out_sum), 64'(prev_sum));
                check("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_sum", 64'(out_sum), 64'(e.s));
                    check("stream_tag", 64'(out_tag), 64'(e.t));
                    n_rx++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_tag   = out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ops;
        bit           sgn;
        logic [3:0]   tag;
        bit           accepted;
        int unsigned  guard;

        // Reset with random inputs applied
        in_valid    = 1'b1;
        in_ops      = {$urandom, $urandom, $urandom, $urandom};
        in_signed   = 1'($urandom_range(0, 1));
        in_tag      = 4'($urandom_range(0, 15));
        out_ready   = 1'($urandom_range(0, 1));
        b_in_valid  = 1'b1;
        b_in_ops    = 24'($urandom);
        repeat (3) @(negedge clk);
        check("rst_vld",   64'(out_valid), 64'd0);
        check("rst_sum",   64'(out_sum),   64'd0);
        check("rst_tag",   64'(out_tag),   64'd0);
        check("rst_b_vld", 64'(b_out_valid), 64'd0);
        check("rst_b_sum", 64'(b_out_sum),   64'd0);
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        out_ready  = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases, default instance
        run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5,
              34'h3_FFFF_FFFC, "unsigned_max");
        run_a(32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd9,
              34'h3_0000_0000, "signed_min");

        // Randomized stream with backpressure
        @(posedge clk); #1;
        prev_stall = 1'b0;
        n_rx       = 0;
        stream_on  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ops       = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) ops = {4{32'h8000_0000}};
            sgn       = 1'($urandom_range(0, 1));
            tag       = 4'($urandom_range(0, 15));
            in_ops    = ops;
            in_signed = sgn;
            in_tag    = tag;
            in_valid  = 1'b1;
            accepted  = 1'b0;
            guard     = 0;
            while (!accepted) begin
                out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (in_ready) begin
                    exp_q.push_back('{s: ref_sum(ops, sgn), t: tag});
                    accepted = 1'b1;
                end
                @(posedge clk); #1;
                guard++;
                if (!accepted && guard > 100) begin
                    check("stream_accept_timeout", 64'd1, 64'd0);
                    accepted = 1'b1;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check("stream_count", 64'(n_rx), 64'd16);
        @(negedge clk);
        stream_on = 1'b0;

        // Reset with three transactions in flight
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ops    = {$urandom, $urandom, $urandom, $urandom};
            in_signed = 1'b0;
            in_tag    = 4'(i + 1);
            in_valid  = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_vld", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", 64'(out_valid), 64'd0);
        check("async_rst_sum", 64'(out_sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_vld", 64'(out_valid), 64'd0);
        end
        run_a(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 4'd3, 34'd10, "post_rst");

        // Odd instance
        run_b(8'hFF, 8'hFF, 8'hFF, 1'b0, 4'd6, 10'h2FD, "odd_unsigned");
        run_b(8'hFF, 8'hFF, 8'hFF, 1'b1, 4'd7, 10'h3FD, "odd_signed");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
